// File: rtl/anc_defs.sv
// Shared widths and window length for the ANC front-end blocks.
package anc_defs;

  localparam int DATA_W  = 7;
  localparam int WIN_LEN = 16;
  localparam int IDX_W   = 4;

endpackage : anc_defs

// File: rtl/mag_greater.sv
// Unsigned strict magnitude comparator: a_gt_b = (a > b).
module mag_greater #(
  parameter int DATA_W = anc_defs::DATA_W
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              a_gt_b
);

  assign a_gt_b = (a > b);

endmodule : mag_greater

// File: rtl/window_peak_detector.sv
// Running-max tracker over fixed windows of accepted samples.
// Reports peak value, its index and a strict over-threshold alarm per window.
module window_peak_detector
  import anc_defs::*;
#(
  parameter int DATA_W  = anc_defs::DATA_W,
  parameter int WIN_LEN = anc_defs::WIN_LEN,
  parameter int IDX_W   = anc_defs::IDX_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_valid,
  input  logic              clear,
  input  logic [DATA_W-1:0] thresh_in,
  output logic [DATA_W-1:0] peak_out,
  output logic [IDX_W-1:0]  peak_idx,
  output logic              peak_valid,
  output logic              alarm,
  output logic              busy
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIN_LEN - 1);

  logic [IDX_W-1:0]  cnt_reg, cnt_next;
  logic [DATA_W-1:0] run_max_reg, run_max_next;
  logic [IDX_W-1:0]  run_idx_reg, run_idx_next;
  logic [DATA_W-1:0] peak_out_reg, peak_out_next;
  logic [IDX_W-1:0]  peak_idx_reg, peak_idx_next;
  logic              alarm_reg, alarm_next;
  logic              peak_valid_reg, peak_valid_next;
  logic              busy_reg, busy_next;

  logic              accept;
  logic              first_sample;
  logic              closing;
  logic              sample_gt_max;
  logic              take_sample;
  logic [DATA_W-1:0] final_max;
  logic [IDX_W-1:0]  final_idx;
  logic              final_gt_thresh;

  assign accept       = sample_valid && !clear;
  assign first_sample = (cnt_reg == '0);
  assign closing      = accept && (cnt_reg == LAST_IDX);

  mag_greater #(.DATA_W(DATA_W)) u_cmp_run (
    .a      (sample_in),
    .b      (run_max_reg),
    .a_gt_b (sample_gt_max)
  );

  // On the first sample run_max is stale, so the load is unconditional.
  assign take_sample = first_sample || sample_gt_max;
  assign final_max   = take_sample ? sample_in : run_max_reg;
  assign final_idx   = take_sample ? cnt_reg : run_idx_reg;

  mag_greater #(.DATA_W(DATA_W)) u_cmp_thresh (
    .a      (final_max),
    .b      (thresh_in),
    .a_gt_b (final_gt_thresh)
  );

  always_comb begin
    cnt_next        = cnt_reg;
    run_max_next    = run_max_reg;
    run_idx_next    = run_idx_reg;
    peak_out_next   = peak_out_reg;
    peak_idx_next   = peak_idx_reg;
    alarm_next      = alarm_reg;
    peak_valid_next = 1'b0;

    if (clear) begin
      cnt_next     = '0;
      run_max_next = '0;
      run_idx_next = '0;
    end else if (accept) begin
      run_max_next = final_max;
      run_idx_next = final_idx;
      if (closing) begin
        cnt_next        = '0;
        peak_out_next   = final_max;
        peak_idx_next   = final_idx;
        alarm_next      = final_gt_thresh;
        peak_valid_next = 1'b1;
      end else begin
        cnt_next = cnt_reg + IDX_W'(1);
      end
    end

    busy_next = (cnt_next != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg        <= '0;
      run_max_reg    <= '0;
      run_idx_reg    <= '0;
      peak_out_reg   <= '0;
      peak_idx_reg   <= '0;
      alarm_reg      <= 1'b0;
      peak_valid_reg <= 1'b0;
      busy_reg       <= 1'b0;
    end else begin
      cnt_reg        <= cnt_next;
      run_max_reg    <= run_max_next;
      run_idx_reg    <= run_idx_next;
      peak_out_reg   <= peak_out_next;
      peak_idx_reg   <= peak_idx_next;
      alarm_reg      <= alarm_next;
      peak_valid_reg <= peak_valid_next;
      busy_reg       <= busy_next;
    end
  end

  assign peak_out   = peak_out_reg;
  assign peak_idx   = peak_idx_reg;
  assign alarm      = alarm_reg;
  assign peak_valid = peak_valid_reg;
  assign busy       = busy_reg;

endmodule : window_peak_detector

// File: tb/tb_window_peak_detector.sv
// Randomized and directed bench for window_peak_detector against a
// window-queue reference model.
module tb_window_peak_detector;
  import anc_defs::*;

  localparam int DW = DATA_W;
  localparam int WL = WIN_LEN;
  localparam int IW = IDX_W;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] sample_in;
  logic          sample_valid;
  logic          clear;
  logic [DW-1:0] thresh_in;
  logic [DW-1:0] peak_out;
  logic [IW-1:0] peak_idx;
  logic          peak_valid;
  logic          alarm;
  logic          busy;

  int total = 0;
  int bad   = 0;

  int win[$];
  int exp_peak  = 0;
  int exp_idx   = 0;
  int exp_alarm = 0;
  int exp_pv    = 0;
  int exp_busy  = 0;

  window_peak_detector #(.DATA_W(DW), .WIN_LEN(WL), .IDX_W(IW)) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .clear        (clear),
    .thresh_in    (thresh_in),
    .peak_out     (peak_out),
    .peak_idx     (peak_idx),
    .peak_valid   (peak_valid),
    .alarm        (alarm),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Reference: collect the accepted samples of the window, then take the
  // maximum and the first position holding it when the window is full.
  task automatic model_step(input bit r, input bit v, input bit c, input int s, input int t);
    int m;
    int mi;
    exp_pv = 0;
    if (r) begin
      win.delete();
      exp_peak  = 0;
      exp_idx   = 0;
      exp_alarm = 0;
    end else if (c) begin
      win.delete();
    end else if (v) begin
      win.push_back(s);
      if (win.size() == WL) begin
        m = win[0];
        for (int i = 1; i < WL; i++)
          if (win[i] > m) m = win[i];
        mi = -1;
        for (int i = WL - 1; i >= 0; i--)
          if (win[i] == m) mi = i;
        exp_peak  = m;
        exp_idx   = mi;
        exp_alarm = (m > t) ? 1 : 0;
        exp_pv    = 1;
        win.delete();
      end
    end
    exp_busy = (win.size() != 0) ? 1 : 0;
  endtask

  task automatic cyc(input bit r, input bit v, input bit c, input int s, input int t);
    rst          = r;
    sample_valid = v;
    clear        = c;
    sample_in    = DW'(s);
    thresh_in    = DW'(t);
    @(posedge clk);
    model_step(r, v, c, s, t);
    #1;
    chk("peak_valid", int'(peak_valid), exp_pv);
    chk("busy",       int'(busy),       exp_busy);
    chk("peak_out",   int'(peak_out),   exp_peak);
    chk("peak_idx",   int'(peak_idx),   exp_idx);
    chk("alarm",      int'(alarm),      exp_alarm);
    if (peak_valid)
      $display("report t=%0t peak_out=%0d peak_idx=%0d alarm=%0d", $time, peak_out, peak_idx, alarm);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  initial begin
    int w1[5];
    int pulses;
    w1 = '{3, 9, 2, 9, 5};
    rst = 1'b1; sample_valid = 1'b0; clear = 1'b0; sample_in = '0; thresh_in = '0;

    cyc(1'b1, 1'b0, 1'b0, 0, 0);
    cyc(1'b1, 1'b1, 1'b0, 55, 0);
    chk("reset_peak", int'(peak_out), 0);
    chk("reset_busy", int'(busy), 0);

    // Tie on 9: earlier index wins.
    for (int i = 0; i < WL; i++)
      cyc(1'b0, 1'b1, 1'b0, (i < 5) ? w1[i] : 0, 8);
    chk("w1_pv", int'(peak_valid), 1);
    chk("w1_peak", int'(peak_out), 9);
    chk("w1_idx", int'(peak_idx), 1);
    chk("w1_alarm", int'(alarm), 1);
    idle();
    chk("w1_pv_drop", int'(peak_valid), 0);
    chk("w1_busy", int'(busy), 0);

    // All-max window and strict threshold.
    for (int i = 0; i < WL; i++) cyc(1'b0, 1'b1, 1'b0, 127, 127);
    chk("max_peak", int'(peak_out), 127);
    chk("max_idx", int'(peak_idx), 0);
    chk("max_alarm", int'(alarm), 0);
    idle();

    // Increasing ramp with gaps: maximum lands on the closing sample.
    pulses = 0;
    for (int i = 0; i < WL; i++) begin
      while ($urandom_range(0, 2) == 0) begin
        idle();
        pulses += int'(peak_valid);
      end
      cyc(1'b0, 1'b1, 1'b0, i, 20);
      pulses += int'(peak_valid);
    end
    chk("ramp_pulses", pulses, 1);
    chk("ramp_peak", int'(peak_out), 15);
    chk("ramp_idx", int'(peak_idx), 15);

    // Back-to-back windows, valid held high.
    for (int i = 0; i < WL; i++) cyc(1'b0, 1'b1, 1'b0, $urandom_range(0, 127), 60);
    chk("b2b_first_pv", int'(peak_valid), 1);
    for (int i = 0; i < WL; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 4, 60);
      if (i < WL - 1) chk("b2b_gap", int'(peak_valid), 0);
    end
    chk("b2b_second_pv", int'(peak_valid), 1);
    chk("b2b_peak", int'(peak_out), 4);
    chk("b2b_idx", int'(peak_idx), 0);
    idle();

    // Clear coinciding with the closing sample suppresses the report.
    for (int i = 0; i < WL - 1; i++) cyc(1'b0, 1'b1, 1'b0, 20, 0);
    cyc(1'b0, 1'b1, 1'b1, 30, 0);
    chk("clr_no_pv", int'(peak_valid), 0);
    chk("clr_hold", int'(peak_out), 4);
    chk("clr_busy", int'(busy), 0);
    for (int i = 0; i < WL; i++) cyc(1'b0, 1'b1, 1'b0, 1, 0);
    chk("clr_next_peak", int'(peak_out), 1);
    chk("clr_next_alarm", int'(alarm), 1);
    idle();

    // Reset mid-window.
    for (int i = 0; i < 7; i++) cyc(1'b0, 1'b1, 1'b0, 50, 0);
    cyc(1'b1, 1'b0, 1'b0, 0, 0);
    chk("mid_rst_peak", int'(peak_out), 0);
    chk("mid_rst_alarm", int'(alarm), 0);
    chk("mid_rst_busy", int'(busy), 0);
    for (int i = 0; i < WL; i++) cyc(1'b0, 1'b1, 1'b0, (i == 3) ? 60 : 10, 59);
    chk("mid_rst_idx", int'(peak_idx), 3);
    chk("mid_rst_peak2", int'(peak_out), 60);

    // Random traffic; narrow value ranges provoke ties.
    for (int n = 0; n < 4000; n++) begin
      bit r, v, c;
      int s;
      r = ($urandom_range(0, 499) == 0);
      v = ($urandom_range(0, 9) < 7);
      c = ($urandom_range(0, 39) == 0);
      s = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 7) : $urandom_range(0, 127);
      if ($urandom_range(0, 9) == 0) s = 127;
      cyc(r, v, c, s, $urandom_range(0, 127));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_window_peak_detector

// File: doc/window_peak_detector.md
Name: window_peak_detector

Overview:
Tracks the running maximum of an unsigned 7-bit sample stream over fixed windows of WIN_LEN accepted samples. At the end of each window it reports the peak, the peak's index within the window, and an over-threshold flag. It sits directly upstream of the ANC error-magnitude logic and feeds the strict greater-than comparison used there. It instantiates that comparison internally for both the running max and the threshold check.

Parameters:
DATA_W, 7, sample and peak width (unsigned)
WIN_LEN, 16, accepted samples per window; must be at least 2
IDX_W, 4, index/counter width; must satisfy 2^IDX_W >= WIN_LEN

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
sample_in  input  DATA_W  unsigned sample
sample_valid  input  1  sample_in is accepted this cycle
clear  input  1  synchronous window abort
thresh_in  input  DATA_W  unsigned alarm threshold, sampled at window close
peak_out  output  DATA_W  peak of last completed window, held
peak_idx  output  IDX_W  index (0..WIN_LEN-1) of that peak, held
peak_valid  output  1  one-cycle pulse: new peak_out/peak_idx/alarm
alarm  output  1  peak_out > thresh_in (strict), held with peak_out
busy  output  1  high while a window holds at least one sample

Behaviour:
- Reset (rst=1 at a clk edge): cnt=0, run_max=0, run_idx=0, peak_out=0, peak_idx=0, peak_valid=0, alarm=0, busy=0. rst overrides every other input.
- Single counter cnt (0..WIN_LEN-1) tracks the position in the window. No other state machine is needed.
  - ACCUM: any cnt.
  - busy = (cnt != 0), registered.
- Accept rule: a sample is accepted when sample_valid=1, clear=0 and rst=0.
- First sample of a window (cnt==0): loads run_max=sample_in and run_idx=0 unconditionally.
- Later samples: update run_max/run_idx to (sample_in, cnt) only if sample_in > run_max, strict and unsigned.
  - Ties keep the earlier index.
- cnt increments on each accepted sample. It does not advance on idle cycles; gaps between samples are allowed.
- Window close: the accepted sample at cnt==WIN_LEN-1.
  - The final max includes that sample, using the same strict rule.
  - Next cycle: peak_out/peak_idx are loaded with the final max and index, alarm = (final max > thresh_in as sampled on the close cycle), and peak_valid=1 for exactly one cycle.
  - cnt wraps to 0 on the close cycle.
- Latency: peak_valid rises one clk after the last sample's accepting edge. A sample accepted in the cycle where peak_valid is high is index 0 of the new window. Back-to-back windows need no bubble.
- clear=1:
  - cnt returns to 0 and run_max/run_idx are discarded.
  - No peak_valid is generated, including when clear coincides with a closing sample; clear wins and the sample is dropped.
  - peak_out/peak_idx/alarm keep their last reported values.
- Outputs peak_out, peak_idx and alarm change only on a report or on reset.
- All arithmetic is unsigned, and there is no saturation. Max value 127 is handled: a later 127 never displaces an earlier 127.

Decomposition:
- Shared package/header (anc_defs): DATA_W, default WIN_LEN, IDX_W. No typedefs are needed.
- One sub-module: mag_greater.
  - Combinational, unsigned, parameterised DATA_W.
  - Ports a, b, a_gt_b = (a > b).
  - Two instances: sample_in vs run_max, and final max vs thresh_in.
- The final-max mux (sample vs run_max on the close cycle) stays in the top module.

Test Plan:
- Reset then window 3,9,2,9,5,... (16 samples, rest 0), thresh_in=8 -> peak_valid one cycle after 16th sample; peak_out=9, peak_idx=1 (tie keeps earlier), alarm=1; busy=0 after.
- All 16 samples =127, thresh_in=127 -> peak_out=127, peak_idx=0, alarm=0 (strict).
- Strictly increasing 0..15 with random sample_valid gaps -> exactly one peak_valid; peak_out=15, peak_idx=15. The max arrives on the closing sample.
- Two back-to-back windows (second all 4, valid held high continuously) -> two peak_valid pulses 16 cycles apart; second gives peak_out=4, peak_idx=0.
- clear asserted with the 16th sample, then 16 samples of 1 -> no pulse at the cleared close; next pulse peak_out=1; peak_out holds its prior value in between.
- rst asserted mid-window (cnt=7) -> all outputs 0 next cycle; next window counts from index 0.
